// File: rtl/rice_core_mul_sequencer_if.sv
// Handshake/data bundle between the EX stage and the iterative multiplier.
// The master drives the operation request; the slave (the sequencer) returns status and result.
interface rice_core_mul_sequencer_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic            i_flush;
  logic [XLEN-1:0] i_rs1_value;
  logic [XLEN-1:0] i_rs2_value;
  logic            i_rs1_signed;
  logic            i_rs2_signed;
  logic            i_rd_high;
  logic            o_ready;
  logic            o_stall;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_flush, i_rs1_value, i_rs2_value,
           i_rs1_signed, i_rs2_signed, i_rd_high,
    input  o_ready, o_stall, o_done, o_result
  );

  modport slave (
    input  i_start, i_flush, i_rs1_value, i_rs2_value,
           i_rs1_signed, i_rs2_signed, i_rd_high,
    output o_ready, o_stall, o_done, o_result
  );
endinterface

// File: rtl/rice_core_mul_sequencer.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU: multiplies operand magnitudes
// over XLEN cycles, then applies the sign and returns the selected half of the product.
module rice_core_mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  rice_core_mul_sequencer_if.slave    bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg;
  logic [CW-1:0]     count_reg;
  logic [XLEN-1:0]   mcand_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic              neg_reg;
  logic              rd_high_reg;
  logic [XLEN-1:0]   result_next_reg;
  logic [XLEN-1:0]   result_hold_reg;

  logic [XLEN-1:0]   rs1_mag;
  logic [XLEN-1:0]   rs2_mag;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] product;
  logic              accept;

  assign accept = (state_reg == IDLE) && bus.i_start && !bus.i_flush;

  always_comb begin
    rs1_mag  = bus.i_rs1_value;
    rs2_mag  = bus.i_rs2_value;
    if (bus.i_rs1_signed && bus.i_rs1_value[XLEN-1])
      rs1_mag = -bus.i_rs1_value;
    if (bus.i_rs2_signed && bus.i_rs2_value[XLEN-1])
      rs2_mag = -bus.i_rs2_value;
    // Carry out of the upper-half add is kept and shifted back into the accumulator.
    sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
    acc_next = {sum, acc_reg[XLEN-1:1]};
    product  = neg_reg ? -acc_next : acc_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      mcand_reg       <= '0;
      mplier_reg      <= '0;
      acc_reg         <= '0;
      neg_reg         <= 1'b0;
      rd_high_reg     <= 1'b0;
      result_next_reg <= '0;
      result_hold_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mcand_reg   <= rs1_mag;
            mplier_reg  <= rs2_mag;
            neg_reg     <= (bus.i_rs1_signed & bus.i_rs1_value[XLEN-1]) ^
                           (bus.i_rs2_signed & bus.i_rs2_value[XLEN-1]);
            rd_high_reg <= bus.i_rd_high;
            acc_reg     <= '0;
            count_reg   <= CW'(XLEN - 1);
            state_reg   <= CALC;
          end
        end
        CALC: begin
          if (bus.i_flush) begin
            state_reg <= IDLE;
          end else begin
            acc_reg    <= acc_next;
            mplier_reg <= mplier_reg >> 1;
            if (count_reg == '0) begin
              // Final step: sign-correct now so the result is ready throughout DONE.
              result_next_reg <= rd_high_reg ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
              state_reg       <= DONE;
            end else begin
              count_reg <= count_reg - 1'b1;
            end
          end
        end
        DONE: begin
          if (!bus.i_flush)
            result_hold_reg <= result_next_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A flush during DONE suppresses the pulse and leaves the previous result visible.
  assign bus.o_ready  = (state_reg == IDLE);
  assign bus.o_stall  = accept || (state_reg == CALC);
  assign bus.o_done   = (state_reg == DONE) && !bus.i_flush;
  assign bus.o_result = ((state_reg == DONE) && !bus.i_flush) ? result_next_reg : result_hold_reg;
endmodule

// File: tb/tb_rice_core_mul_sequencer.sv
// Directed bench for the iterative multiplier: vector table for results/latency plus
// hand-written flush, reset and back-to-back sequences.
module tb_rice_core_mul_sequencer;
  localparam int XLEN = 32;

  typedef struct {
    string       name;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        s1;
    logic        s2;
    logic        hi;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  logic [31:0] last_result = '0;
  vec_t vecs [10];

  always #5 clk = ~clk;

  rice_core_mul_sequencer_if #(.XLEN(XLEN)) mul_if ();

  rice_core_mul_sequencer #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (mul_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic drive_op(input vec_t v);
    mul_if.i_rs1_value  = v.rs1;
    mul_if.i_rs2_value  = v.rs2;
    mul_if.i_rs1_signed = v.s1;
    mul_if.i_rs2_signed = v.s2;
    mul_if.i_rd_high    = v.hi;
    mul_if.i_start      = 1'b1;
  endtask

  // Start at the next negedge, wait for o_done, check latency, result and stall behaviour.
  task automatic do_op(input vec_t v);
    int lat;
    int stall_bad;
    @(negedge clk);
    drive_op(v);
    #1;
    check({v.name, " ready@start"}, 32'(mul_if.o_ready), 32'd1);
    check({v.name, " stall@start"}, 32'(mul_if.o_stall), 32'd1);
    @(posedge clk);
    #1 mul_if.i_start = 1'b0;
    lat = 0;
    stall_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mul_if.o_done) begin
        lat = k;
        break;
      end
      if (!mul_if.o_stall) stall_bad++;
    end
    check({v.name, " latency"}, 32'(lat), 32'd33);
    check({v.name, " result"}, mul_if.o_result, v.exp);
    check({v.name, " stall@done"}, 32'(mul_if.o_stall), 32'd0);
    check({v.name, " stall gaps"}, 32'(stall_bad), 32'd0);
    if (lat != 0) last_result = v.exp;
  endtask

  task automatic count_dones(input string name, input int cycles);
    int dones;
    dones = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (mul_if.o_done) dones++;
    end
    check(name, 32'(dones), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   lat;
    vecs[0] = '{"mul 7x-3",        32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFEB};
    vecs[1] = '{"mulh min*min",    32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 32'h4000_0000};
    vecs[2] = '{"mulhu ones",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE};
    vecs[3] = '{"mulu lo ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0001};
    vecs[4] = '{"mulhsu -1xmax",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{"mulhsu -1x0",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[6] = '{"mulhu x16",       32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h0000_0001};
    vecs[7] = '{"mul x16",         32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h2345_6780};
    vecs[8] = '{"mulh min*1",      32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[9] = '{"mulhsu min*2^31", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'hC000_0000};

    mul_if.i_start      = 1'b0;
    mul_if.i_flush      = 1'b0;
    mul_if.i_rs1_value  = '0;
    mul_if.i_rs2_value  = '0;
    mul_if.i_rs1_signed = 1'b0;
    mul_if.i_rs2_signed = 1'b0;
    mul_if.i_rd_high    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready",  32'(mul_if.o_ready), 32'd1);
    check("reset stall",  32'(mul_if.o_stall), 32'd0);
    check("reset done",   32'(mul_if.o_done), 32'd0);
    check("reset result", mul_if.o_result, 32'd0);
    rst_n = 1'b1;

    // Table vectors run back-to-back: each start lands in the cycle right after DONE.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i]);
      if (i == 0) begin
        @(negedge clk);
        check("done pulse width", 32'(mul_if.o_done), 32'd0);
        check("ready after done", 32'(mul_if.o_ready), 32'd1);
      end
    end

    // Flush at CALC cycle 10.
    v = '{"flush calc", 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 32'h0000_0051};
    @(negedge clk);
    drive_op(v);
    @(posedge clk);
    #1 mul_if.i_start = 1'b0;
    repeat (10) @(negedge clk);
    mul_if.i_flush = 1'b1;
    @(posedge clk);
    #1 mul_if.i_flush = 1'b0;
    @(negedge clk);
    check("flush calc ready",  32'(mul_if.o_ready), 32'd1);
    check("flush calc stall",  32'(mul_if.o_stall), 32'd0);
    check("flush calc done",   32'(mul_if.o_done), 32'd0);
    check("flush calc result", mul_if.o_result, last_result);
    count_dones("flush calc no done", 40);
    do_op(v);

    // Start together with flush in IDLE is not accepted.
    @(negedge clk);
    drive_op(v);
    mul_if.i_flush = 1'b1;
    #1;
    check("start+flush stall", 32'(mul_if.o_stall), 32'd0);
    @(posedge clk);
    #1;
    mul_if.i_start = 1'b0;
    mul_if.i_flush = 1'b0;
    @(negedge clk);
    check("start+flush ready", 32'(mul_if.o_ready), 32'd1);
    count_dones("start+flush no done", 40);

    // Flush during DONE: no pulse, previous result kept.
    v = '{"flush done", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0000_000F};
    @(negedge clk);
    drive_op(v);
    @(posedge clk);
    #1 mul_if.i_start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mul_if.o_done) begin
        lat = k;
        break;
      end
    end
    check("flush done latency", 32'(lat), 32'd33);
    mul_if.i_flush = 1'b1;
    #1;
    check("flush done pulse",  32'(mul_if.o_done), 32'd0);
    check("flush done result", mul_if.o_result, last_result);
    @(posedge clk);
    #1 mul_if.i_flush = 1'b0;
    @(negedge clk);
    check("flush done held", mul_if.o_result, last_result);
    check("flush done ready", 32'(mul_if.o_ready), 32'd1);

    // Reset asserted mid-CALC.
    v = '{"reset calc", 32'h0000_0011, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0022};
    @(negedge clk);
    drive_op(v);
    @(posedge clk);
    #1 mul_if.i_start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst calc ready",  32'(mul_if.o_ready), 32'd1);
    check("rst calc stall",  32'(mul_if.o_stall), 32'd0);
    check("rst calc done",   32'(mul_if.o_done), 32'd0);
    check("rst calc result", mul_if.o_result, 32'd0);
    rst_n = 1'b1;
    last_result = '0;
    count_dones("rst calc no done", 40);
    do_op(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
